regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (waddr/wdata/wren/is_upper) between
//  NUM_REQ write-back requesters, for example the ALU, the load unit and the debug port.
//  Each requester uses a valid/ready handshake. Arbitration is round-robin.
//  The winning write is registered and driven to the register file one cycle later.
//  A pending mask tells hazard logic which register has a write in flight.
// PARAMETERS
//  NUM_REQ    3  number of requesters (2..8)
//  ZERO_HARD  1  1: a write to r0 is accepted but wren stays low; 0: r0 is writable
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  req_valid   in   NUM_REQ    requester i has a write pending
//  req_ready   out  NUM_REQ    requester i is accepted this cycle (one-hot or zero)
//  req_waddr   in   5*NUM_REQ  packed destination addresses, slice i = [5i+4:5i]
//  req_wdata   in   32*NUM_REQ packed write data, slice i = [32i+31:32i]
//  req_upper   in   NUM_REQ    per-requester is_upper flag (the register file shifts data <<16)
//  rf_waddr    out  5          to register file waddr
//  rf_wdata    out  32         to register file wdata
//  rf_wren     out  1          to register file wren
//  rf_upper    out  1          to register file is_upper
//  pend_mask   out  32         bit k=1: a write to rk is in the output stage this cycle
//  last_grant  out  $clog2(NUM_REQ)  index of the most recently accepted requester
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately)
//   - rf_wren=0, rf_waddr=0, rf_wdata=0, rf_upper=0.
//   - pend_mask=0, last_grant=NUM_REQ-1, so requester 0 has top priority first.
//   - req_ready=0 while rst is high.
//  Arbitration (combinational, same cycle)
//   - Search order starts at last_grant+1 mod NUM_REQ and wraps around.
//   - The first requester with req_valid=1 is granted; req_ready is driven one-hot.
//   - If no requester is valid: req_ready=0 and last_grant holds.
//   - The register file accepts a write every cycle, so there is never back-pressure
//     from downstream: some valid requester is always granted.
//  Handshake
//   - A transfer happens when valid & ready are both high.
//   - The requester holds valid, waddr, wdata and upper stable until ready.
//   - The requester must not drop valid before it is accepted; the bench checks this.
//  Output stage (1 register, latency 1)
//   - On a transfer at edge N: rf_waddr/rf_wdata/rf_upper take the granted slice at edge N.
//   - rf_wren=1 for exactly one cycle, unless ZERO_HARD=1 and waddr=0, which gives rf_wren=0.
//   - pend_mask is the one-hot of rf_waddr when rf_wren=1, otherwise 0.
//   - last_grant updates at the same edge.
//   - With no transfer, rf_wren=0 next cycle; the other rf_* outputs hold their last value.
//  Fairness
//   - A continuously valid requester is granted within NUM_REQ cycles.
//   - Back-to-back grants go to the same requester only when it is the only valid one.
//  Simultaneous events
//   - Two requesters targeting the same register in consecutive cycles: both writes are
//     issued in grant order; the last write wins. No merging, no reordering.
//  Reset mid-operation
//   - Clears the output stage immediately, so an in-flight write is lost (rf_wren=0).
//   - Requesters re-present their writes after reset.
// STRUCTURE
//  Shared package: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, zero-register index constant.
//  One sub-module, rr_arbiter:
//   - Inputs: req vector and last-grant pointer.
//   - Outputs: one-hot grant and encoded index.
//   - Purely combinational; the pointer register lives in the parent.
//  Remaining RTL: slice mux, output register stage, pend_mask decoder.
// TESTING
//  1. Reset, then single requester 1 valid with addr=5, data=0x1234 ->
//     ready[1] in the same cycle; next cycle rf_wren=1, rf_waddr=5, pend_mask=0x20.
//  2. All 3 valid for 6 cycles with NUM_REQ=3 -> grant order 0,1,2,0,1,2; rf_wren high every cycle.
//  3. Write to r0 with ZERO_HARD=1 -> ready=1; next cycle rf_wren=0 and pend_mask=0.
//     Same stimulus with ZERO_HARD=0 -> rf_wren=1.
//  4. req_upper=1, data=0xABCD, addr=3 -> rf_upper=1, rf_wdata=0xABCD.
//     A register-file model then reads r3=0xABCD0000.
//  5. Requesters 0 and 2 write r7 (0x11 then 0x22) in consecutive grants ->
//     the register-file model ends with r7=0x22.
//  6. Assert rst while rf_wren=1 -> rf_wren, pend_mask and req_ready drop before the next edge.
//     After release, requester 0 is granted first.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // r0 is the hard-wired zero register when ZERO_HARD is set
  localparam reg_addr_t ZERO_REG = '0;

  // One write-back request as seen by the register-file port
  typedef struct packed {
    reg_addr_t waddr;
    xlen_t     wdata;
    logic      upper;
  } wb_req_t;

  // One-hot decode of a register address, used for the hazard mask
  function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request after the last grant.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: none; the pointer is held by the parent and only moves on a transfer.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int   cand;
  logic found;

  // Scan from last_i+1 with wrap-around; the first asserted request wins
  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last_i) + off) % N;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ requesters, round-robin.
// Latency: 1 cycle from accepted request to rf_* outputs.
// Backpressure: none downstream; one valid requester is always accepted per cycle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter bit ZERO_HARD = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_waddr,
  input  logic [XLEN*NUM_REQ-1:0]       req_wdata,
  input  logic [NUM_REQ-1:0]            req_upper,
  output logic [REG_ADDR_W-1:0]         rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic                          rf_wren,
  output logic                          rf_upper,
  output logic [NUM_REGS-1:0]           pend_mask,
  output logic [$clog2(NUM_REQ)-1:0]    last_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_vld;
  logic               xfer;
  wb_req_t            sel;

  wb_req_t          stage_d, stage_q;
  logic             wren_d, wren_q;
  logic [IDX_W-1:0] last_d, last_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (any_vld)
  );

  // No requester is accepted while reset is held
  assign req_ready = rst ? '0 : gnt;
  assign xfer      = any_vld & ~rst;

  // Pick the granted requester's address, data and upper flag
  always_comb begin
    sel       = '0;
    sel.waddr = req_waddr[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
    sel.wdata = req_wdata[int'(gnt_idx)*XLEN +: XLEN];
    sel.upper = req_upper[gnt_idx];
  end

  // Load the output stage on a transfer; r0 writes are swallowed when hard-wired
  always_comb begin
    stage_d = stage_q;
    wren_d  = 1'b0;
    last_d  = last_q;
    if (xfer) begin
      stage_d = sel;
      wren_d  = !(ZERO_HARD && (sel.waddr == ZERO_REG));
      last_d  = gnt_idx;
    end
  end

  // Output register and grant pointer; reset drops any in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      wren_q  <= 1'b0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      stage_q <= stage_d;
      wren_q  <= wren_d;
      last_q  <= last_d;
    end
  end

  assign rf_waddr   = stage_q.waddr;
  assign rf_wdata   = stage_q.wdata;
  assign rf_upper   = stage_q.upper;
  assign rf_wren    = wren_q;
  assign last_grant = last_q;

  // Hazard mask follows the write actually issued this cycle
  assign pend_mask = wren_q ? addr_onehot(stage_q.waddr) : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then randomized traffic.
// Latency: checks ready in-cycle and rf_* one edge after each transfer.
// Backpressure: requesters hold valid until accepted, then drop or re-present.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_ready0, req_upper;
  logic [5*N-1:0]  req_waddr;
  logic [32*N-1:0] req_wdata;
  logic [4:0]      rf_waddr, rf_waddr0;
  logic [31:0]     rf_wdata, rf_wdata0, pend_mask, pend_mask0;
  logic            rf_wren, rf_wren0, rf_upper, rf_upper0;
  logic [IW-1:0]   last_grant, last_grant0;

  regfile_wb_arbiter #(.NUM_REQ(N), .ZERO_HARD(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_upper(req_upper),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wren(rf_wren), .rf_upper(rf_upper),
    .pend_mask(pend_mask), .last_grant(last_grant));

  regfile_wb_arbiter #(.NUM_REQ(N), .ZERO_HARD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_upper(req_upper),
    .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0), .rf_wren(rf_wren0), .rf_upper(rf_upper0),
    .pend_mask(pend_mask0), .last_grant(last_grant0));

  int total = 0;
  int bad   = 0;

  // Reference state: rotation pointer, expected output stage, register file
  int          m_last;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_upper, m_wren;
  logic [31:0] rfm [32];
  int          last_gnt;
  int          wait_cnt [N];

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d, input bit u);
    req_valid[i]        = v;
    req_waddr[5*i +: 5] = a;
    req_wdata[32*i +: 32] = d;
    req_upper[i]        = u;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] ep;
    ep = m_wren ? (32'd1 << m_addr) : 32'd0;
    chk(tag, "wren",  32'(rf_wren),    32'(m_wren));
    chk(tag, "waddr", 32'(rf_waddr),   32'(m_addr));
    chk(tag, "wdata", rf_wdata,        m_data);
    chk(tag, "upper", 32'(rf_upper),   32'(m_upper));
    chk(tag, "pend",  pend_mask,       ep);
    chk(tag, "last",  32'(last_grant), 32'(m_last));
  endtask

  // Hold reset for one edge, check the cleared state, then release
  task automatic do_reset(input string tag);
    rst = 1'b1;
    m_last = N - 1; m_addr = '0; m_data = '0; m_upper = 1'b0; m_wren = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    #1;
    chk(tag, "ready", 32'(req_ready), 32'd0);
    chk(tag, "ready0", 32'(req_ready0), 32'd0);
    check_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: predict the grant from the rotation rule, then the registered write
  task automatic step(input string tag);
    int g;
    int c;
    logic [N-1:0] er;
    #1;
    g = -1;
    for (int off = 1; off <= N; off++) begin
      c = (m_last + off) % N;
      if (g < 0 && req_valid[c]) g = c;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk(tag, "ready",  32'(req_ready),  32'(er));
    chk(tag, "ready0", 32'(req_ready0), 32'(er));
    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        chk(tag, "fair", 32'(wait_cnt[i] < N), 32'd1);
        wait_cnt[i] = 0;
      end else if (req_valid[i]) begin
        wait_cnt[i]++;
      end else begin
        wait_cnt[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_addr  = req_waddr[5*g +: 5];
      m_data  = req_wdata[32*g +: 32];
      m_upper = req_upper[g];
      m_wren  = (m_addr != 5'd0);
      m_last  = g;
    end else begin
      m_wren = 1'b0;
    end
    last_gnt = g;
    check_outputs(tag);
    chk(tag, "wren0", 32'(rf_wren0), 32'(g >= 0));
    if (rf_wren) rfm[rf_waddr] = rf_upper ? (rf_wdata << 16) : rf_wdata;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    req_upper = '0;
    last_gnt  = -1;
    for (int r = 0; r < 32; r++) rfm[r] = '0;

    // Reset state and a single requester
    do_reset("rst");
    set_req(1, 1'b1, 5'd5, 32'h1234, 1'b0);
    step("t1");
    chk("t1", "gnt", 32'(last_gnt), 32'd1);
    chk("t1", "wren_c", 32'(rf_wren), 32'd1);
    chk("t1", "pend_c", pend_mask, 32'h20);

    // All valid: strict rotation from requester 0
    do_reset("t2rst");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(10 + i), 32'(100 * k + i), 1'b0);
      step("t2");
      chk("t2", "order", 32'(last_gnt), 32'(k % N));
      chk("t2", "wren_c", 32'(rf_wren), 32'd1);
    end
    req_valid = '0;

    // Write to r0: swallowed only when the zero register is hard-wired
    set_req(2, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    step("t3");
    chk("t3", "wren_c", 32'(rf_wren), 32'd0);
    chk("t3", "pend_c", pend_mask, 32'd0);
    chk("t3", "wren0_c", 32'(rf_wren0), 32'd1);

    // Upper-half write lands shifted in the register file
    set_req(1, 1'b1, 5'd3, 32'hABCD, 1'b1);
    step("t4");
    chk("t4", "upper_c", 32'(rf_upper), 32'd1);
    chk("t4", "wdata_c", rf_wdata, 32'hABCD);
    chk("t4", "r3", rfm[3], 32'hABCD0000);

    // Same destination from two requesters: last granted write wins
    do_reset("t5rst");
    set_req(0, 1'b1, 5'd7, 32'h11, 1'b0);
    set_req(2, 1'b1, 5'd7, 32'h22, 1'b0);
    step("t5a");
    chk("t5a", "gnt", 32'(last_gnt), 32'd0);
    step("t5b");
    chk("t5b", "gnt", 32'(last_gnt), 32'd2);
    chk("t5", "r7", rfm[7], 32'h22);

    // Reset while a write is in the output stage
    set_req(1, 1'b1, 5'd9, 32'h99, 1'b0);
    step("t6a");
    chk("t6a", "wren_c", 32'(rf_wren), 32'd1);
    req_valid = '1;
    rst = 1'b1;
    #1;
    chk("t6", "wren_rst", 32'(rf_wren), 32'd0);
    chk("t6", "pend_rst", pend_mask, 32'd0);
    chk("t6", "ready_rst", 32'(req_ready), 32'd0);
    do_reset("t6rst");
    req_valid = '1;
    step("t6b");
    chk("t6b", "gnt", 32'(last_gnt), 32'd0);
    req_valid = '0;

    // Randomized traffic; requesters hold their request until accepted
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 55)
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
